pht_counter_table: RTL
======================

# pht_counter_table

Pattern history table for the branch predictor: 256 two-bit saturating counters indexed by an 8-bit address. Sits directly downstream of the 8-to-256 address decoder, which turns the update address into the one-hot row-write enable for the counter array. Provides a registered taken/not-taken prediction per lookup and trains counters from resolved-branch updates.

## Interface
- `INDEX_W`, 8, address width; fixed to the decoder width.
- `ENTRIES`, 256, counter count (= 2**INDEX_W).
- `CTR_RESET`, 2'b01, counter value after reset or clear (weakly not-taken).

Ports, clock and reset first:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `lookup_valid`  in  1  lookup request this cycle.
- `lookup_address`  in  8  counter index to read.
- `pred_valid`  out  1  registered; high one cycle after an accepted lookup.
- `pred_taken`  out  1  registered; MSB of the counter read.
- `pred_ctr`  out  2  registered; full counter value read.
- `update_valid`  in  1  training request this cycle.
- `update_address`  in  8  counter index to train.
- `update_taken`  in  1  resolved direction: 1 = taken, 0 = not-taken.
- `clear`  in  1  synchronous flush of all counters to `CTR_RESET`.

## Operation
- Counter encoding:
  - 00 strong not-taken.
  - 01 weak not-taken.
  - 10 weak taken.
  - 11 strong taken.
- Prediction is `pred_taken = ctr[1]`.
- Update rules:
  - Taken: ctr <= (ctr == 11) ? 11 : ctr + 1.
  - Not-taken: ctr <= (ctr == 00) ? 00 : ctr − 1.
  - Arithmetic is 2-bit with no wrap. 11+taken stays 11; 00+not-taken stays 00.
- Write path:
  - `update_address` is decoded to a 256-bit one-hot write enable, gated by `update_valid`.
  - Exactly one row is written per update; all other rows hold.
- Read path:
  - The counter at `lookup_address` is captured into the output registers.
  - `pred_valid` follows `lookup_valid` delayed one cycle.
  - When `pred_valid` is 0, `pred_taken` and `pred_ctr` hold their last values.
- `clear`:
  - Loads `CTR_RESET` into all 256 counters at the next edge.
  - Has priority over a same-cycle `update_valid`; that update is dropped.
  - Does not affect `pred_valid` sequencing.
- No backpressure: lookups and updates are accepted every cycle.

## Timing
- Reset values, applied asynchronously while `rst` is high:
  - Every counter = `CTR_RESET`.
  - `pred_valid` = 0, `pred_taken` = 0, `pred_ctr` = 2'b00.
- Reset mid-operation: an in-flight lookup is discarded; `pred_valid` is 0 on the first edge after `rst` falls.
- Lookup latency: exactly 1 cycle (request at edge N, result valid after edge N+1).
- Update latency: the counter changes at the edge that samples `update_valid`.
  - A lookup of that index in the following cycle sees the new value.
- Same-cycle lookup and update to the same index: result is macro-dependent; see Configuration.
- Same-cycle lookup and update to different indices: independent; the lookup sees the pre-edge value.
- Same-cycle lookup and `clear`: result is macro-dependent; see Configuration.

## Configuration
- `PHT_BYPASS_EN` defined:
  - Same-cycle lookup/update collision returns the post-update counter value.
  - Lookup coinciding with `clear` returns `CTR_RESET`.
- `PHT_BYPASS_EN` undefined:
  - The lookup returns the pre-edge (stale) value in both cases.
- The array-write behaviour is identical in both builds.

## Structure
- Package `pht_pkg`:
  - `ctr_t` (2-bit logic).
  - Constants `CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_ST`.
  - `PHT_INDEX_W` = 8 and `PHT_ENTRIES` = 256.
  - Function `ctr_next(ctr_t, logic taken)` implementing saturation.
- Sub-module: instantiate the existing `decoder_8to256` (`address` ← `update_address`, `decoded_output` → row enables).
  - No other sub-modules.
- Array is 256 flop-based `ctr_t` entries (no SRAM macro), so async reset and single-cycle clear are possible.

## Test plan
- Reset then lookup of indices 0, 5, 130, 255 → each `pred_valid` = 1 one cycle later, `pred_ctr` = 01, `pred_taken` = 0.
- Three taken updates to index 5, then lookup 5 → `pred_ctr` = 11, `pred_taken` = 1.
  - A fourth taken update, then lookup → still 11 (saturation).
- Two not-taken updates to index 130, then lookup 130 → `pred_ctr` = 00.
  - Lookup 129 and 131 → 01 (one-hot isolation).
- Index 7 trained to 10, then same-cycle lookup 7 + update 7 taken → `pred_ctr` = 11 with `PHT_BYPASS_EN`, 10 without.
  - A follow-up lookup returns 11 in both builds.
- Index 5 = 11, then `clear` and update 5 not-taken in the same cycle → following lookup 5 returns 01 (clear wins).
- Lookup 5 issued, `rst` pulsed high mid-cycle before the next edge → `pred_valid` = 0 immediately; all counters read back as 01 after reset.

Source files
------------

// File: rtl/pht_pkg.sv
// Shared types and helpers for the pattern history table: 2-bit counter
// encoding, table geometry and the saturating counter update.
package pht_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  localparam int PHT_INDEX_W = 8;
  localparam int PHT_ENTRIES = 256;

  // Saturating step: never wraps past strong taken or strong not-taken.
  function automatic ctr_t ctr_next(ctr_t ctr, logic taken);
    ctr_t res;
    if (taken) begin
      res = (ctr == CTR_ST) ? CTR_ST : ctr_t'(ctr + 2'd1);
    end else begin
      res = (ctr == CTR_SNT) ? CTR_SNT : ctr_t'(ctr - 2'd1);
    end
    return res;
  endfunction

endpackage

// File: rtl/decoder_8to256.sv
// 8-to-256 one-hot address decoder feeding the counter array row enables.
module decoder_8to256 (
  input  logic [7:0]   address,
  output logic [255:0] decoded_output
);

  assign decoded_output = 256'd1 << address;

endmodule

// File: rtl/pht_counter_table.sv
// Pattern history table: 256 flop-based 2-bit saturating counters with a
// registered lookup port. Define PHT_BYPASS_EN to forward same-cycle
// update/clear results into the lookup.
module pht_counter_table
  import pht_pkg::*;
#(
  parameter int   INDEX_W   = PHT_INDEX_W,
  parameter int   ENTRIES   = PHT_ENTRIES,
  parameter ctr_t CTR_RESET = CTR_WNT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lookup_valid,
  input  logic [INDEX_W-1:0] lookup_address,
  output logic               pred_valid,
  output logic               pred_taken,
  output logic [1:0]         pred_ctr,
  input  logic               update_valid,
  input  logic [INDEX_W-1:0] update_address,
  input  logic               update_taken,
  input  logic               clear
);

  ctr_t                   ctr_q [ENTRIES];
  logic [PHT_ENTRIES-1:0] row_dec;
  logic [ENTRIES-1:0]     row_en;
  ctr_t                   rd_ctr_p0;
  logic                   vld_p1;
  ctr_t                   ctr_p1;

  decoder_8to256 u_decoder (
    .address        (update_address),
    .decoded_output (row_dec)
  );

  assign row_en = row_dec & {ENTRIES{update_valid}};

  // Counter array: clear overrides any same-cycle training write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RESET;
    end else if (clear) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RESET;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (row_en[i]) ctr_q[i] <= ctr_next(ctr_q[i], update_taken);
      end
    end
  end

  always_comb begin
    rd_ctr_p0 = ctr_q[lookup_address];
`ifdef PHT_BYPASS_EN
    if (clear) begin
      rd_ctr_p0 = CTR_RESET;
    end else if (update_valid && (update_address == lookup_address)) begin
      rd_ctr_p0 = ctr_next(ctr_q[lookup_address], update_taken);
    end
`endif
  end

  // Stage p1: registered prediction; data holds when no lookup is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      ctr_p1 <= CTR_SNT;
    end else begin
      vld_p1 <= lookup_valid;
      if (lookup_valid) ctr_p1 <= rd_ctr_p0;
    end
  end

  assign pred_valid = vld_p1;
  assign pred_ctr   = ctr_p1;
  assign pred_taken = ctr_p1[1];

endmodule
